elevator_look_ctrl: RTL and testbench

- Parametrised next-generation car controller. It replaces FIFO-ordered target fetching with a pending-request bitmap and LOOK scheduling, so the car stops at every requested floor it passes.
- Adds per-floor travel timing, a timed door-open dwell and request validation.
- Sits between the call-button aggregator and the car drive/door actuators. The car position, direction and door signals keep the existing encoding.

---
 rtl/elevator_look_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_elevator_look_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_look_ctrl.sv
// elevator_look_ctrl: LOOK-scheduled car controller with a pending-request bitmap,
// per-floor travel timing, timed door dwell and request range checking.
// Optional emergency stop (estop port and HALT state) when ELEV_ESTOP_EN is defined.
module elevator_look_ctrl #(
  parameter int NUM_FLOORS  = 16,
  parameter int FLOOR_W     = 4,
  parameter int MOVE_CYCLES = 2,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef ELEV_ESTOP_EN
  input  logic                  estop,
`endif
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic [FLOOR_W-1:0]    floor,
  output logic [1:0]            dir,
  output logic                  door,
  output logic                  arrived,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  req_err
);

  localparam logic [1:0] DIR_UP   = 2'b00;
  localparam logic [1:0] DIR_DN   = 2'b01;
  localparam logic [1:0] DIR_IDLE = 2'b11;

  // Move timer holds 0..MOVE_CYCLES-1, door timer holds remaining open cycles 1..DOOR_CYCLES.
  localparam int MT_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DT_W = $clog2(DOOR_CYCLES + 1);
  localparam logic [MT_W-1:0]    MOVE_RELOAD = MT_W'(MOVE_CYCLES - 1);
  localparam logic [DT_W-1:0]    DOOR_RELOAD = DT_W'(DOOR_CYCLES);
  localparam logic [FLOOR_W:0]   NF_EXT      = (FLOOR_W + 1)'(NUM_FLOORS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
`ifdef ELEV_ESTOP_EN
    , S_HALT = 2'd3
`endif
  } state_t;

  state_t                  state_q;
  logic [FLOOR_W-1:0]      floor_q;
  logic [1:0]              dir_q;
  logic                    door_q;
  logic                    arrived_q;
  logic [NUM_FLOORS-1:0]   pending_q;
  logic [NUM_FLOORS-1:0]   pending_d;
  logic                    req_err_q;
  logic                    last_dn_q;   // 1 when the last non-idle direction was DOWN
  logic [MT_W-1:0]         mtmr_q;
  logic [DT_W-1:0]         dtmr_q;

  logic [NUM_FLOORS-1:0]   above_vec, below_vec;
  logic [NUM_FLOORS-1:0]   here_oh, step_oh, req_oh;
  logic [NUM_FLOORS-1:0]   clr_vec, set_vec;
  logic [FLOOR_W-1:0]      step_floor;
  logic                    eff_dn, above_any, below_any, ahead_any, behind_any, new_dn;
  logic                    at_here, at_step, serve_idle, serve_move;
  logic                    req_in_range, req_ok, door_absorb, serve_absorb;

  // Sweep direction in force: when idle (or door opened from idle) fall back to last_dir.
  assign eff_dn     = (dir_q == DIR_IDLE) ? last_dn_q : (dir_q == DIR_DN);
  assign step_floor = eff_dn ? (floor_q - 1'b1) : (floor_q + 1'b1);

  // Per-floor comparisons against the car position, the next floor and the request floor.
  generate
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
      localparam logic [FLOOR_W:0] GI_F = (FLOOR_W + 1)'(gi);
      assign above_vec[gi] = pending_q[gi] & (GI_F > {1'b0, floor_q});
      assign below_vec[gi] = pending_q[gi] & (GI_F < {1'b0, floor_q});
      assign here_oh[gi]   = (GI_F == {1'b0, floor_q});
      assign step_oh[gi]   = (GI_F == {1'b0, step_floor});
      assign req_oh[gi]    = (GI_F == {1'b0, req_floor});
    end
  endgenerate

  assign above_any  = |above_vec;
  assign below_any  = |below_vec;
  assign ahead_any  = eff_dn ? below_any : above_any;
  assign behind_any = eff_dn ? above_any : below_any;
  // LOOK: keep the current sweep if anything lies ahead, otherwise reverse.
  assign new_dn     = ahead_any ? eff_dn : ~eff_dn;
  assign at_here    = |(pending_q & here_oh);
  assign at_step    = |(pending_q & step_oh);

  // Which bit (if any) is being served on this edge.
  assign serve_idle = (state_q == S_IDLE) && at_here;
  assign serve_move = (state_q == S_MOVE) && (mtmr_q == '0) && ahead_any && at_step;
  assign clr_vec    = ({NUM_FLOORS{serve_idle}} & here_oh) | ({NUM_FLOORS{serve_move}} & step_oh);

  // Request validation and absorption; a request for the floor being served never sets its bit.
  assign req_in_range = ({1'b0, req_floor} < NF_EXT);
  assign req_ok       = req_valid && req_in_range;
  assign door_absorb  = req_ok && (state_q == S_DOOR) && (req_floor == floor_q);
  assign serve_absorb = req_ok && (|(clr_vec & req_oh));
  assign set_vec      = (req_ok && !door_absorb && !serve_absorb) ? req_oh : '0;
  assign pending_d    = (pending_q & ~clr_vec) | set_vec;

  // Controller FSM: state, position, direction, timers, bitmap and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      floor_q   <= '0;
      dir_q     <= DIR_IDLE;
      door_q    <= 1'b0;
      arrived_q <= 1'b0;
      pending_q <= '0;
      req_err_q <= 1'b0;
      last_dn_q <= 1'b0;
      mtmr_q    <= '0;
      dtmr_q    <= '0;
    end
`ifdef ELEV_ESTOP_EN
    else if (estop) begin
      state_q   <= S_HALT;
      dir_q     <= DIR_IDLE;
      door_q    <= 1'b0;
      arrived_q <= 1'b0;
      pending_q <= '0;
      req_err_q <= 1'b0;
      mtmr_q    <= '0;
      dtmr_q    <= '0;
    end
`endif
    else begin
      arrived_q <= 1'b0;
      req_err_q <= req_valid && !req_in_range;
      pending_q <= pending_d;
      case (state_q)
        S_IDLE: begin
          if (at_here) begin
            state_q   <= S_DOOR;
            door_q    <= 1'b1;
            arrived_q <= 1'b1;
            dtmr_q    <= DOOR_RELOAD;
          end else if (above_any || below_any) begin
            state_q   <= S_MOVE;
            dir_q     <= new_dn ? DIR_DN : DIR_UP;
            last_dn_q <= new_dn;
            mtmr_q    <= MOVE_RELOAD;
          end else begin
            dir_q <= DIR_IDLE;
          end
        end
        S_MOVE: begin
          if (mtmr_q != '0) begin
            mtmr_q <= mtmr_q - MT_W'(1);
          end else if (ahead_any) begin
            floor_q <= step_floor;
            mtmr_q  <= MOVE_RELOAD;
            if (at_step) begin
              state_q   <= S_DOOR;
              door_q    <= 1'b1;
              arrived_q <= 1'b1;
              dtmr_q    <= DOOR_RELOAD;
            end
          end else begin
            // Nothing left ahead: stop at this floor rather than overrun.
            state_q <= S_IDLE;
            dir_q   <= DIR_IDLE;
          end
        end
        S_DOOR: begin
          if (door_absorb) begin
            dtmr_q <= DOOR_RELOAD;
          end else if (dtmr_q > DT_W'(1)) begin
            dtmr_q <= dtmr_q - DT_W'(1);
          end else begin
            door_q <= 1'b0;
            dtmr_q <= '0;
            if (ahead_any || behind_any) begin
              state_q   <= S_MOVE;
              dir_q     <= new_dn ? DIR_DN : DIR_UP;
              last_dn_q <= new_dn;
              mtmr_q    <= MOVE_RELOAD;
            end else begin
              state_q <= S_IDLE;
              dir_q   <= DIR_IDLE;
            end
          end
        end
        default: begin
          // HALT release (or an illegal code) resumes from IDLE with last_dir kept.
          state_q <= S_IDLE;
          dir_q   <= DIR_IDLE;
          door_q  <= 1'b0;
        end
      endcase
    end
  end

  assign floor   = floor_q;
  assign dir     = dir_q;
  assign door    = door_q;
  assign arrived = arrived_q;
  assign pending = pending_q;
  assign req_err = req_err_q;

endmodule

// File: tb/tb_elevator_look_ctrl.sv
// Scoreboard bench for elevator_look_ctrl: stimulus queues expected arrive/close/error
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_elevator_look_ctrl;

  localparam int NF = 16;
  localparam int FW = 5;

  localparam int EV_ERR   = 0;
  localparam int EV_CLOSE = 1;
  localparam int EV_ARR   = 2;

  typedef struct {
    int kind;
    int flr;
    int cyc;
  } ev_t;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic [FW-1:0] floor;
  logic [1:0]    dir;
  logic          door;
  logic          arrived;
  logic [NF-1:0] pending;
  logic          req_err;
`ifdef ELEV_ESTOP_EN
  logic          estop;
`endif

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  logic door_prev = 1'b0;

  elevator_look_ctrl #(
    .NUM_FLOORS (NF),
    .FLOOR_W    (FW),
    .MOVE_CYCLES(2),
    .DOOR_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef ELEV_ESTOP_EN
    .estop    (estop),
`endif
    .req_valid(req_valid),
    .req_floor(req_floor),
    .floor    (floor),
    .dir      (dir),
    .door     (door),
    .arrived  (arrived),
    .pending  (pending),
    .req_err  (req_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cyc > 5000) begin
      $display("FAIL watchdog: cycle %0d exceeded budget 5000", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  function automatic string kname(input int k);
    case (k)
      EV_ERR:   return "req_err";
      EV_CLOSE: return "close";
      default:  return "arrive";
    endcase
  endfunction

  task automatic push(input int kind, input int flr, input int c);
    ev_t e;
    e.kind = kind;
    e.flr  = flr;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input int flr);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got %s floor %0d at cycle %0d, none expected", kname(kind), flr, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.flr != flr || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got %s floor %0d cycle %0d, expected %s floor %0d cycle %0d",
                 kname(kind), flr, cyc, kname(e.kind), e.flr, e.cyc);
      end else begin
        $display("event %s floor %0d cycle %0d ok", kname(kind), flr, cyc);
      end
    end
  endtask

  // Monitor: every output event is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      door_prev = 1'b0;
    end else begin
      if (req_err) got(EV_ERR, int'(floor));
      if (door_prev && !door) got(EV_CLOSE, int'(floor));
      if (arrived) got(EV_ARR, int'(floor));
      door_prev = door;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end else begin
      $display("check %s = %0h at cycle %0d ok", name, act, cyc);
    end
  endtask

  task automatic nstep;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) nstep();
  endtask

  // Presents one request strobe; the next rising edge (cyc+1 on entry) captures it.
  task automatic send(input int f);
    req_valid = 1'b1;
    req_floor = FW'(f);
    nstep();
    req_valid = 1'b0;
    $display("request floor %0d captured at cycle %0d", f, cyc);
  endtask

  task automatic wait_drain;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) nstep();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d events outstanding, expected 0 at cycle %0d", exp_q.size(), cyc);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    nstep();
    nstep();
    rst = 1'b0;
  endtask

  int k, m;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_floor = '0;
`ifdef ELEV_ESTOP_EN
    estop     = 1'b0;
`endif
    repeat (3) nstep();
    chk("reset floor", 32'(floor), 0);
    chk("reset dir", 32'(dir), 3);
    chk("reset door", 32'(door), 0);
    chk("reset arrived", 32'(arrived), 0);
    chk("reset pending", 32'(pending), 0);
    chk("reset req_err", 32'(req_err), 0);
    rst = 1'b0;
    nstep();

    // Single request for floor 3 from idle at floor 0.
    k = cyc + 1;
    push(EV_ARR, 3, k + 7);
    push(EV_CLOSE, 3, k + 11);
    send(3);
    chk("t1 pending", 32'(pending), 32'h0008);
    chk("t1 dir at k", 32'(dir), 3);
    nstep();
    chk("t1 dir at k+1", 32'(dir), 0);
    wait_until(k + 11);
    chk("t1 dir idle", 32'(dir), 3);
    chk("t1 floor", 32'(floor), 3);
    wait_drain();

    // Upward sweep to 5 with a stop at 2, then reverse to serve 0.
    do_reset();
    k = cyc + 1;
    push(EV_ARR, 2, k + 5);
    push(EV_CLOSE, 2, k + 9);
    push(EV_ARR, 5, k + 15);
    push(EV_CLOSE, 5, k + 19);
    push(EV_ARR, 0, k + 29);
    push(EV_CLOSE, 0, k + 33);
    send(5);
    nstep();
    send(0);
    nstep();
    chk("t2 floor before inject", 32'(floor), 1);
    send(2);
    chk("t2 pending", 32'(pending), 32'h0025);
    wait_until(k + 20);
    chk("t2 reversed dir", 32'(dir), 1);
    wait_until(k + 33);
    chk("t2 final dir", 32'(dir), 3);
    chk("t2 final pending", 32'(pending), 0);
    chk("t2 final floor", 32'(floor), 0);
    wait_drain();

    // Travel to 4, then a request at the current floor and a repeat during the dwell.
    k = cyc + 1;
    push(EV_ARR, 4, k + 9);
    push(EV_CLOSE, 4, k + 13);
    send(4);
    wait_until(k + 13);
    wait_drain();
    m = cyc + 1;
    push(EV_ARR, 4, m + 1);
    push(EV_CLOSE, 4, m + 7);
    send(4);
    nstep();
    chk("t3 door open", 32'(door), 1);
    chk("t3 floor held", 32'(floor), 4);
    nstep();
    send(4);
    chk("t3 pending absorbed", 32'(pending), 0);
    wait_until(m + 5);
    chk("t3 door extended", 32'(door), 1);
    wait_until(m + 7);
    chk("t3 door closed", 32'(door), 0);
    chk("t3 floor", 32'(floor), 4);
    wait_drain();

    // Out-of-range requests.
    k = cyc + 1;
    push(EV_ERR, 4, k);
    send(16);
    nstep();
    chk("t4 req_err width", 32'(req_err), 0);
    chk("t4 pending", 32'(pending), 0);
    chk("t4 dir", 32'(dir), 3);
    k = cyc + 1;
    push(EV_ERR, 4, k);
    send(20);
    nstep();
    chk("t4 pending 2", 32'(pending), 0);
    chk("t4 floor", 32'(floor), 4);
    wait_drain();

    // Asynchronous reset while moving from 2 toward 3.
    do_reset();
    k = cyc + 1;
    send(9);
    wait_until(k + 6);
    chk("t5 floor before reset", 32'(floor), 2);
    rst = 1'b1;
    #1;
    chk("t5 async floor", 32'(floor), 0);
    chk("t5 async dir", 32'(dir), 3);
    chk("t5 async door", 32'(door), 0);
    chk("t5 async pending", 32'(pending), 0);
    nstep();
    nstep();
    rst = 1'b0;
    nstep();
    nstep();
    chk("t5 stays idle", 32'(dir), 3);

`ifdef ELEV_ESTOP_EN
    // Emergency stop at floor 3 heading for 6, then a fresh request after release.
    k = cyc + 1;
    send(6);
    wait_until(k + 7);
    chk("t6 floor before estop", 32'(floor), 3);
    estop = 1'b1;
    nstep();
    chk("t6 halt floor", 32'(floor), 3);
    chk("t6 halt dir", 32'(dir), 3);
    chk("t6 halt pending", 32'(pending), 0);
    chk("t6 halt door", 32'(door), 0);
    send(5);
    chk("t6 request ignored", 32'(pending), 0);
    estop = 1'b0;
    nstep();
    k = cyc + 1;
    push(EV_ARR, 1, k + 5);
    push(EV_CLOSE, 1, k + 9);
    send(1);
    nstep();
    chk("t6 dir down", 32'(dir), 1);
    wait_until(k + 9);
    wait_drain();
`endif

    nstep();
    chk("scoreboard empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
